// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes and FSM state encoding
// Purpose: ALU_Ctrl code values (identical to what the ALU control decoder
// emits) and the IDLE/RUN/FIX state type of the multi-cycle ALU.
// Ports: none (package).
package alu_pkg;

  localparam logic [5:0] ALU_ADD  = 6'b000000;
  localparam logic [5:0] ALU_SUB  = 6'b000001;
  localparam logic [5:0] ALU_MULT = 6'b000010;
  localparam logic [5:0] ALU_DIV  = 6'b000011;
  localparam logic [5:0] ALU_OR   = 6'b000100;
  localparam logic [5:0] ALU_AND  = 6'b000101;
  localparam logic [5:0] ALU_NOT  = 6'b000110;
  localparam logic [5:0] ALU_SLT  = 6'b000111;
  localparam logic [5:0] ALU_SLE  = 6'b100100;
  localparam logic [5:0] ALU_SGE  = 6'b100101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } alu_state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// rtl/alu_muldiv_iter.sv - iterative unsigned shift-add multiply / restoring divide
// Purpose: W-step unsigned engine working on operand magnitudes.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load         capture a_mag/b_mag/op_div and preload the step counter to W-1
//   op_div       0 = multiply, 1 = divide
//   a_mag        multiplier / dividend magnitude
//   b_mag        multiplicand / divisor magnitude
//   step         perform one iteration
//   last         current step is the final (W-th) one
//   acc          2W-bit accumulator: {hi, lo} = product, or {remainder, quotient}
module alu_muldiv_iter #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           op_div,
  input  logic [W-1:0]   a_mag,
  input  logic [W-1:0]   b_mag,
  input  logic           step,
  output logic           last,
  output logic [2*W-1:0] acc
);

  localparam int CW = $clog2(W);

  logic [W-1:0]   operand_b;
  logic           div_mode;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] acc_next;

  // Multiply: conditional add into the high half, then shift right with carry.
  logic [W:0] mul_sum;
  // Divide: shift left into a W+1-bit partial remainder, trial subtract.
  logic [W:0] rem_sh;
  logic [W:0] rem_diff;
  logic       rem_ge;

  always_comb begin
    mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, operand_b} : {(W+1){1'b0}});
    rem_sh   = {acc[2*W-1:W], acc[W-1]};
    rem_diff = rem_sh - {1'b0, operand_b};
    rem_ge   = (rem_sh >= {1'b0, operand_b});
    if (div_mode) begin
      // Partial remainder stays below the divisor, so W bits always suffice.
      acc_next = {(rem_ge ? rem_diff[W-1:0] : rem_sh[W-1:0]), acc[W-2:0], rem_ge};
    end else begin
      acc_next = {mul_sum, acc[W-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      operand_b <= '0;
      div_mode  <= 1'b0;
      cnt       <= '0;
    end else if (load) begin
      acc       <= {{W{1'b0}}, a_mag};
      operand_b <= b_mag;
      div_mode  <= op_div;
      cnt       <= CW'(W-1);
    end else if (step) begin
      acc <= acc_next;
      cnt <= cnt - 1'b1;
    end
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - execute-stage ALU with iterative signed mult/div
// Purpose: single-cycle add/sub/or/and/not/slt/sle/sge; mult and div take
// W+1 extra cycles on alu_muldiv_iter with Busy asserted.
// Ports:
//   Clock, Reset_n  clock, asynchronous active-low reset
//   Start           launch operation (sampled only in IDLE)
//   ALU_Ctrl        6-bit operation code
//   A, B            operands
//   Result          registered main result (product low / quotient)
//   Hi              registered product high word / remainder, 0 otherwise
//   Zero            registered Result == 0
//   Busy            mult/div in progress
//   Done            one-cycle completion pulse
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         Clock,
  input  logic         Reset_n,
  input  logic         Start,
  input  logic [5:0]   ALU_Ctrl,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic [W-1:0] Result,
  output logic [W-1:0] Hi,
  output logic         Zero,
  output logic         Busy,
  output logic         Done
);

  alu_state_t state, state_next;

  logic           load, wr_en;
  logic [W-1:0]   res_next, hi_next;
  logic [W-1:0]   alu_out;
  logic [W-1:0]   a_mag, b_mag;
  logic           is_mult, is_div;
  logic           sign_q, sign_r, op_div_q;
  logic           eng_last;
  logic [2*W-1:0] eng_acc;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quot_fix, rem_fix;

  assign is_mult = (ALU_Ctrl == ALU_MULT);
  assign is_div  = (ALU_Ctrl == ALU_DIV);
  assign a_mag   = A[W-1] ? -A : A;
  assign b_mag   = B[W-1] ? -B : B;

  // Single-cycle results; unknown codes fall back to add.
  always_comb begin
    alu_out = A + B;
    case (ALU_Ctrl)
      ALU_ADD: alu_out = A + B;
      ALU_SUB: alu_out = A - B;
      ALU_OR:  alu_out = A | B;
      ALU_AND: alu_out = A & B;
      ALU_NOT: alu_out = ~A;
      ALU_SLT: alu_out = {{(W-1){1'b0}}, ($signed(A) <  $signed(B))};
      ALU_SLE: alu_out = {{(W-1){1'b0}}, ($signed(A) <= $signed(B))};
      ALU_SGE: alu_out = {{(W-1){1'b0}}, ($signed(A) >= $signed(B))};
      default: alu_out = A + B;
    endcase
  end

  // Sign correction of the unsigned engine result. Most-negative / -1 falls
  // out naturally: magnitude 2^(W-1) negated wraps back to most-negative.
  assign prod_fix = sign_q ? -eng_acc : eng_acc;
  assign quot_fix = sign_q ? -eng_acc[W-1:0] : eng_acc[W-1:0];
  assign rem_fix  = sign_r ? -eng_acc[2*W-1:W] : eng_acc[2*W-1:W];

  always_comb begin
    state_next = state;
    load       = 1'b0;
    wr_en      = 1'b0;
    res_next   = alu_out;
    hi_next    = '0;
    case (state)
      ST_IDLE: begin
        if (Start) begin
          if (is_mult || (is_div && (B != '0))) begin
            load       = 1'b1;
            state_next = ST_RUN;
          end else begin
            wr_en = 1'b1;
            if (is_div) begin
              // Divide by zero completes immediately without iterating.
              res_next = '1;
              hi_next  = A;
            end
          end
        end
      end
      ST_RUN: begin
        if (eng_last) state_next = ST_FIX;
      end
      ST_FIX: begin
        wr_en      = 1'b1;
        state_next = ST_IDLE;
        res_next   = op_div_q ? quot_fix : prod_fix[W-1:0];
        hi_next    = op_div_q ? rem_fix  : prod_fix[2*W-1:W];
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      Result   <= '0;
      Hi       <= '0;
      Zero     <= 1'b0;
      Done     <= 1'b0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      op_div_q <= 1'b0;
    end else begin
      Done <= wr_en;
      if (wr_en) begin
        Result <= res_next;
        Hi     <= hi_next;
        Zero   <= (res_next == '0);
      end
      if (load) begin
        sign_q   <= A[W-1] ^ B[W-1];
        sign_r   <= A[W-1];
        op_div_q <= is_div;
      end
    end
  end

  assign Busy = (state != ST_IDLE);

  alu_muldiv_iter #(.W(W)) u_engine (
    .clk    (Clock),
    .rst_n  (Reset_n),
    .load   (load),
    .op_div (is_div),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .step   (state == ST_RUN),
    .last   (eng_last),
    .acc    (eng_acc)
  );

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - randomized self-checking bench for alu_multicycle
module tb_alu_multicycle;

  localparam int W = 32;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          start;
  logic [5:0]    alu_ctrl;
  logic [W-1:0]  a, b;
  logic [W-1:0]  result, hi;
  logic          zero, busy, done;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  alu_multicycle #(.W(W)) dut (
    .Clock    (clock),
    .Reset_n  (reset_n),
    .Start    (start),
    .ALU_Ctrl (alu_ctrl),
    .A        (a),
    .B        (b),
    .Result   (result),
    .Hi       (hi),
    .Zero     (zero),
    .Busy     (busy),
    .Done     (done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain signed arithmetic on 64-bit integers.
  function automatic void model(input logic [5:0] c, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic [31:0] h, output bit multi);
    longint sx, sy, p, q, m;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    h = '0;
    multi = 1'b0;
    case (c)
      6'b000001: r = x - y;
      6'b000100: r = x | y;
      6'b000101: r = x & y;
      6'b000110: r = ~x;
      6'b000111: r = (sx <  sy) ? 32'd1 : 32'd0;
      6'b100100: r = (sx <= sy) ? 32'd1 : 32'd0;
      6'b100101: r = (sx >= sy) ? 32'd1 : 32'd0;
      6'b000010: begin
        p = sx * sy;
        r = p[31:0];
        h = p[63:32];
        multi = 1'b1;
      end
      6'b000011: begin
        if (y == 32'd0) begin
          r = 32'hFFFF_FFFF;
          h = x;
        end else begin
          q = sx / sy;
          m = sx % sy;
          r = q[31:0];
          h = m[31:0];
          multi = 1'b1;
        end
      end
      default: r = x + y;
    endcase
  endfunction

  // Apply one operation; inject_at > 0 pulses an extra add Start before
  // the edge with that index (counted from the accepting edge).
  task automatic run_op(input logic [5:0] c, input logic [31:0] x, input logic [31:0] y,
                        input int inject_at, input string tag);
    logic [31:0] er, eh;
    bit multi;
    int edges, busy_cnt;
    bit got_done;
    model(c, x, y, er, eh, multi);
    @(negedge clock);
    start = 1'b1; alu_ctrl = c; a = x; b = y;
    @(posedge clock); #1;
    if (!multi) begin
      check({tag, " done"}, done, 1);
      check({tag, " busy"}, busy, 0);
    end else begin
      check({tag, " busy start"}, busy, 1);
      edges = 0; busy_cnt = 0; got_done = 0;
      while (!got_done && edges < 3 * W) begin
        if (busy) busy_cnt++;
        @(negedge clock);
        start    = (edges + 1 == inject_at);
        alu_ctrl = start ? 6'b000000 : 6'($urandom);
        a        = $urandom;
        b        = $urandom;
        @(posedge clock); #1;
        edges++;
        if (done) got_done = 1;
      end
      check({tag, " latency"}, 64'(edges), 64'(W + 1));
      check({tag, " busy cycles"}, 64'(busy_cnt), 64'(W + 1));
      check({tag, " busy end"}, busy, 0);
    end
    check({tag, " result"}, result, er);
    check({tag, " hi"}, hi, eh);
    check({tag, " zero"}, zero, (er == 32'd0));
    @(negedge clock);
    start = 1'b0;
    @(posedge clock); #1;
    check({tag, " done pulse"}, done, 0);
    check({tag, " idle busy"}, busy, 0);
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  logic [5:0] codes [10] = '{6'b000000, 6'b000001, 6'b000010, 6'b000011, 6'b000100,
                             6'b000101, 6'b000110, 6'b000111, 6'b100100, 6'b100101};

  initial begin
    bit seen_done, seen_busy;
    logic [5:0] c;
    reset_n = 1'b0; start = 1'b0; alu_ctrl = '0; a = '0; b = '0;
    repeat (2) @(posedge clock);
    #1;
    check("reset result", result, 0);
    check("reset hi", hi, 0);
    check("reset zero", zero, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    @(negedge clock);
    reset_n = 1'b1;

    run_op(6'b000000, 32'd7, 32'd5, 0, "add");
    run_op(6'b000001, 32'd5, 32'd5, 0, "sub zero");
    run_op(6'b000111, 32'hFFFF_FFFF, 32'd1, 0, "slt");
    run_op(6'b100101, 32'hFFFF_FFFF, 32'd1, 0, "sge");
    run_op(6'b100100, 32'h8000_0000, 32'h8000_0000, 0, "sle eq");
    run_op(6'b111111, 32'd2, 32'd3, 0, "undef add");
    run_op(6'b000010, 32'hFFFF_FFFD, 32'd4, 0, "mult neg");
    run_op(6'b000010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mult m1");
    run_op(6'b000011, 32'hFFFF_FFF9, 32'd2, 0, "div neg");
    run_op(6'b000011, 32'd10, 32'd0, 0, "div zero");
    run_op(6'b000011, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div ovf");
    run_op(6'b000010, 32'd1234, 32'hFFFF_0000, 5, "mult start in run");
    run_op(6'b000011, 32'd1000, 32'hFFFF_FFF3, W + 1, "div start in fix");

    // Reset in the middle of a division.
    @(negedge clock);
    start = 1'b1; alu_ctrl = 6'b000011; a = 32'd100; b = 32'd7;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (10) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("rst mid result", result, 0);
    check("rst mid hi", hi, 0);
    check("rst mid zero", zero, 0);
    check("rst mid busy", busy, 0);
    check("rst mid done", done, 0);
    @(negedge clock);
    reset_n = 1'b1;
    seen_done = 0; seen_busy = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done) seen_done = 1;
      if (busy) seen_busy = 1;
    end
    check("rst no done", seen_done, 0);
    check("rst no busy", seen_busy, 0);
    run_op(6'b000000, 32'd40, 32'd2, 0, "add after rst");

    for (int i = 0; i < 150; i++) begin
      c = ($urandom_range(0, 7) == 0) ? 6'($urandom) : codes[$urandom_range(0, 9)];
      run_op(c, rnd_operand(), rnd_operand(), 0, $sformatf("rand%0d op%b", i, c));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
